dot_row_feeder: RTL and testbench
=================================

# dot_row_feeder

Upstream feeder for `eight_Dot_Product_Multiply_with_control_row`. It fetches one matrix row (bank A) and the vector (bank B) from synchronous RAM, one NI-lane package at a time. It zero-pads the tail package and presents each package pair with a one-cycle `outsider_read_now` strobe and a constant `no_of_multiples`. After each row it waits for the dot-product unit's `prepare_my_new_input` before streaming the next row, for `rows` rows per start.

## Interface
- `NOE`, 10: elements per row/vector (≥1).
- `NI`, 8: lanes per package (even).
- `PKG`, derived = ceil(NOE/NI): packages per row.
- `GAP`, 4: cycles between consecutive `outsider_read_now` pulses within a row (≥3).
- `AW`, 10: RAM address width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin a job; sampled in IDLE only.
- `rows` in 16: number of rows in the job; sampled with `start`.
- `a_rd_en` out 1: bank A read strobe.
- `a_addr` out AW: bank A address, equal to `row*PKG + pkg`, truncated to AW.
- `a_rd_data` in 32*NI: bank A data, valid 1 cycle after `a_rd_en`.
- `b_rd_en` out 1: bank B read strobe, always identical to `a_rd_en`.
- `b_addr` out AW: bank B address, equal to `pkg`.
- `b_rd_data` in 32*NI: bank B data, valid 1 cycle after `b_rd_en`.
- `first_row_input` out 32*NI: matrix package. Element k of the package is at `[32*(NI-k)-1 -: 32]`.
- `second_row_input` out 32*NI: vector package, same lane order.
- `outsider_read_now` out 1: one-cycle strobe; the package is valid at the strobe.
- `no_of_multiples` out 32: holds PKG while `busy`, otherwise 0.
- `prepare_my_new_input` in 1: row-consumed pulse from the dot-product unit.
- `busy` out 1: high from the cycle after an accepted `start` through `done`.
- `done` out 1: one-cycle pulse when the last row is released.

## Operation
- States:
  - IDLE
  - FETCH: `rd_en`=1 with the current addresses.
  - LOAD: capture the masked RAM data into the package registers.
  - PRESENT: `outsider_read_now`=1.
  - HOLD: counts GAP-3 cycles.
  - ROW_WAIT
- Counters:
  - `row`, 0..rows-1.
  - `pkg`, 0..PKG-1.
  - `gap_cnt`.
- Transitions:
  - IDLE, `start`=1 and `rows`≠0 → FETCH. Clear `row` and `pkg`, latch `rows`.
  - IDLE, `start`=1 and `rows`=0 → `done` pulse next cycle. No reads, `busy` stays 0.
  - FETCH → LOAD → PRESENT.
  - PRESENT, `pkg`<PKG-1 → `pkg`+1, then HOLD. HOLD goes to FETCH after GAP-3 cycles; with GAP=3 it goes directly to FETCH.
  - PRESENT, `pkg`=PKG-1 → ROW_WAIT.
  - ROW_WAIT, `prepare_my_new_input`=1 and `row`<rows-1 → `row`+1, `pkg`=0, FETCH.
  - ROW_WAIT, `prepare_my_new_input`=1 and last row → `done`=1 for one cycle, then IDLE.
- Masking: lane k of package p is forced to 0 in both outputs when `p*NI + k ≥ NOE`. RAM contents in pad lanes are irrelevant.
- Package registers hold their value until the next LOAD. They are not cleared between rows or at `done`.
- `prepare_my_new_input` is ignored outside ROW_WAIT.
- `start` is ignored while `busy`.

## Timing
- Reset state: IDLE, all outputs 0 (`rd_en`s, addresses, packages, strobe, `no_of_multiples`, `busy`, `done`), all counters 0.
- `reset` low at any time aborts the job immediately. Nothing is resumed after release.
- `start` accepted at edge 0:
  - FETCH in cycle 1.
  - Data captured at the end of cycle 2.
  - First `outsider_read_now` in cycle 3.
- Within a row, strobes are exactly GAP cycles apart. Package data is stable from the strobe cycle for at least GAP-1 following cycles.
- Row turnaround: `prepare_my_new_input` seen in ROW_WAIT at edge t → FETCH in cycle t+1 → next strobe in cycle t+3.
- `done` is asserted in the cycle after the final `prepare_my_new_input`. `busy` falls in the same cycle.
- Row address wraps modulo 2^AW with no error flag.

## Test plan
- NOE=10, NI=8, rows=1, A[0]=lanes 1..8, B[0]=all 2.0, A[1]/B[1]=all 0xFFFFFFFF:
  - Strobes at cycles 3 and 7; `no_of_multiples`=2.
  - Second package has lanes 0-1 from RAM and lanes 2-7 zero.
  - Pulse `prepare_my_new_input` at cycle 10 → `done` at cycle 11.
- rows=3: addresses A=0,1 | 2,3 | 4,5 and B=0,1 repeating. No FETCH before each `prepare_my_new_input`.
- `prepare_my_new_input` pulsed during PRESENT and HOLD → ignored. The row ends only on a pulse in ROW_WAIT.
- rows=0 with `start` → `done` next cycle, `a_rd_en`/`b_rd_en` never high.
- `reset` low in HOLD of row 1 → all outputs 0 within the same cycle. After release, a new `start` with rows=1 streams from address 0.
- GAP=3, NOE=16: strobes back-to-back 3 apart, no HOLD cycles, no padding applied.

Source files
------------

// File: rtl/dot_row_feeder.sv
// Row/vector package feeder for the eight-lane dot-product unit: fetches bank A row
// packages and bank B vector packages, zero-pads the tail and strobes each pair out.
module dot_row_feeder #(
  parameter int unsigned NOE = 10,
  parameter int unsigned NI  = 8,
  parameter int unsigned GAP = 4,
  parameter int unsigned AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       rows,
  output logic              a_rd_en,
  output logic [AW-1:0]     a_addr,
  input  logic [32*NI-1:0]  a_rd_data,
  output logic              b_rd_en,
  output logic [AW-1:0]     b_addr,
  input  logic [32*NI-1:0]  b_rd_data,
  output logic [32*NI-1:0]  first_row_input,
  output logic [32*NI-1:0]  second_row_input,
  output logic              outsider_read_now,
  output logic [31:0]       no_of_multiples,
  input  logic              prepare_my_new_input,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   PKG       = (NOE + NI - 1) / NI;
  localparam int unsigned   PW        = (PKG > 1) ? $clog2(PKG) : 1;
  localparam int unsigned   GW        = $clog2(GAP);
  localparam logic [PW-1:0] PKG_LAST  = PW'(PKG - 1);
  localparam logic [GW-1:0] HOLD_LAST = GW'((GAP > 3) ? GAP - 4 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PRESENT,
    S_HOLD,
    S_ROW_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       row_q, row_d;
  logic [15:0]       rows_q, rows_d;
  logic [PW-1:0]     pkg_q, pkg_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [AW-1:0]     base_q, base_d;
  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     a_addr_q, a_addr_d;
  logic [AW-1:0]     b_addr_q, b_addr_d;
  logic [32*NI-1:0]  pkg_a_q, pkg_a_d;
  logic [32*NI-1:0]  pkg_b_q, pkg_b_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       nom_q, nom_d;
  logic              enter_fetch;
  logic [32*NI-1:0]  lane_mask;

  // Lanes whose global element index runs past NOE are padding.
  always_comb begin
    lane_mask = '0;
    for (int unsigned k = 0; k < NI; k++) begin
      if (32'(pkg_q) * NI + k < NOE) lane_mask[32*(NI-k)-1 -: 32] = '1;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rows_d      = rows_q;
    pkg_d       = pkg_q;
    gap_d       = gap_q;
    base_d      = base_q;
    rd_en_d     = 1'b0;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    pkg_a_d     = pkg_a_q;
    pkg_b_d     = pkg_b_q;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    nom_d       = nom_q;
    enter_fetch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (rows != 16'd0) begin
            state_d     = S_FETCH;
            row_d       = '0;
            pkg_d       = '0;
            base_d      = '0;
            rows_d      = rows;
            busy_d      = 1'b1;
            nom_d       = 32'(PKG);
            enter_fetch = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d  = S_PRESENT;
        pkg_a_d  = a_rd_data & lane_mask;
        pkg_b_d  = b_rd_data & lane_mask;
        strobe_d = 1'b1;
      end
      S_PRESENT: begin
        if (pkg_q == PKG_LAST) begin
          state_d = S_ROW_WAIT;
        end else begin
          pkg_d = pkg_q + 1'b1;
          if (GAP == 3) begin
            state_d     = S_FETCH;
            enter_fetch = 1'b1;
          end else begin
            state_d = S_HOLD;
            gap_d   = '0;
          end
        end
      end
      S_HOLD: begin
        if (gap_q == HOLD_LAST) begin
          state_d     = S_FETCH;
          enter_fetch = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_ROW_WAIT: begin
        if (prepare_my_new_input) begin
          if (row_q != rows_q - 16'd1) begin
            state_d     = S_FETCH;
            row_d       = row_q + 16'd1;
            pkg_d       = '0;
            base_d      = base_q + AW'(PKG);
            enter_fetch = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            nom_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Row base advances by PKG per row, so row*PKG+pkg needs no multiplier.
    if (enter_fetch) begin
      rd_en_d  = 1'b1;
      a_addr_d = base_d + AW'(pkg_d);
      b_addr_d = AW'(pkg_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      rows_q   <= '0;
      pkg_q    <= '0;
      gap_q    <= '0;
      base_q   <= '0;
      rd_en_q  <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      pkg_a_q  <= '0;
      pkg_b_q  <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nom_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rows_q   <= rows_d;
      pkg_q    <= pkg_d;
      gap_q    <= gap_d;
      base_q   <= base_d;
      rd_en_q  <= rd_en_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      pkg_a_q  <= pkg_a_d;
      pkg_b_q  <= pkg_b_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nom_q    <= nom_d;
    end
  end

  assign a_rd_en           = rd_en_q;
  assign b_rd_en           = rd_en_q;
  assign a_addr            = a_addr_q;
  assign b_addr            = b_addr_q;
  assign first_row_input   = pkg_a_q;
  assign second_row_input  = pkg_b_q;
  assign outsider_read_now = strobe_q;
  assign no_of_multiples   = nom_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_dot_row_feeder.sv
// Scoreboard bench for dot_row_feeder: two instances (NOE=10/GAP=4 and NOE=16/GAP=3)
// fed from behavioural RAMs; expectations are derived from the row/package/padding rules.
module tb_dot_row_feeder;
  localparam int unsigned NI = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned W  = 32 * NI;

  typedef struct { int inst; logic [W-1:0] a; logic [W-1:0] b; int unsigned cyc; } pkt_t;
  typedef struct { int inst; logic [AW-1:0] a; logic [AW-1:0] b; int unsigned cyc; } adr_t;
  typedef struct { int inst; int unsigned cyc; } evt_t;

  pkt_t pq[$];
  adr_t aq[$];
  evt_t dq[$];

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int strobe_cnt [2] = '{0, 0};
  logic [W-1:0] last_a [2];
  logic [W-1:0] last_b [2];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start [2] = '{1'b0, 1'b0};
  logic [15:0] rows [2] = '{16'd0, 16'd0};
  logic prep [2] = '{1'b0, 1'b0};
  logic a_rd_en [2];
  logic b_rd_en [2];
  logic [AW-1:0] a_addr [2];
  logic [AW-1:0] b_addr [2];
  logic [W-1:0] a_rd_data [2];
  logic [W-1:0] b_rd_data [2];
  logic [W-1:0] fri [2];
  logic [W-1:0] sri [2];
  logic orn [2];
  logic [31:0] nom [2];
  logic busy [2];
  logic done [2];
  logic [W-1:0] mem_a [2][64];
  logic [W-1:0] mem_b [2][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot_row_feeder #(.NOE(10), .NI(NI), .GAP(4), .AW(AW)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start[0]), .rows(rows[0]),
    .a_rd_en(a_rd_en[0]), .a_addr(a_addr[0]), .a_rd_data(a_rd_data[0]),
    .b_rd_en(b_rd_en[0]), .b_addr(b_addr[0]), .b_rd_data(b_rd_data[0]),
    .first_row_input(fri[0]), .second_row_input(sri[0]),
    .outsider_read_now(orn[0]), .no_of_multiples(nom[0]),
    .prepare_my_new_input(prep[0]), .busy(busy[0]), .done(done[0])
  );

  dot_row_feeder #(.NOE(16), .NI(NI), .GAP(3), .AW(AW)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start[1]), .rows(rows[1]),
    .a_rd_en(a_rd_en[1]), .a_addr(a_addr[1]), .a_rd_data(a_rd_data[1]),
    .b_rd_en(b_rd_en[1]), .b_addr(b_addr[1]), .b_rd_data(b_rd_data[1]),
    .first_row_input(fri[1]), .second_row_input(sri[1]),
    .outsider_read_now(orn[1]), .no_of_multiples(nom[1]),
    .prepare_my_new_input(prep[1]), .busy(busy[1]), .done(done[1])
  );

  // Synchronous RAMs: data one cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_rd_en[i]) a_rd_data[i] <= mem_a[i][a_addr[i][5:0]];
      if (b_rd_en[i]) b_rd_data[i] <= mem_b[i][b_addr[i][5:0]];
    end
  end

  function automatic int unsigned noe_of(input int i);
    return (i == 0) ? 10 : 16;
  endfunction
  function automatic int unsigned gap_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction
  function automatic int unsigned pkg_of(input int i);
    return (noe_of(i) + NI - 1) / NI;
  endfunction

  function automatic logic [W-1:0] pad(input logic [W-1:0] d, input int unsigned p,
                                       input int unsigned noe);
    logic [W-1:0] r;
    r = d;
    for (int unsigned k = 0; k < NI; k++)
      if (p * NI + k >= noe) r[32*(NI-k)-1 -: 32] = '0;
    return r;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Scoreboard monitor: pops the oldest expectation of the matching instance.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        int idx;
        if (orn[i]) begin
          idx = -1;
          for (int j = 0; j < pq.size(); j++) if (idx < 0 && pq[j].inst == i) idx = j;
          if (idx < 0) miss($sformatf("strobe%0d_unexpected", i));
          else begin
            chkw($sformatf("first_row%0d", i), fri[i], pq[idx].a);
            chkw($sformatf("second_row%0d", i), sri[i], pq[idx].b);
            chk32($sformatf("strobe_cycle%0d", i), cyc, pq[idx].cyc);
            pq.delete(idx);
          end
          strobe_cnt[i]++;
          last_a[i] = fri[i];
          last_b[i] = sri[i];
        end
        if (a_rd_en[i] || b_rd_en[i]) begin
          chk32($sformatf("rd_en_pair%0d", i), 32'(b_rd_en[i]), 32'(a_rd_en[i]));
          idx = -1;
          for (int j = 0; j < aq.size(); j++) if (idx < 0 && aq[j].inst == i) idx = j;
          if (idx < 0) miss($sformatf("fetch%0d_unexpected", i));
          else begin
            chk32($sformatf("a_addr%0d", i), 32'(a_addr[i]), 32'(aq[idx].a));
            chk32($sformatf("b_addr%0d", i), 32'(b_addr[i]), 32'(aq[idx].b));
            chk32($sformatf("fetch_cycle%0d", i), cyc, aq[idx].cyc);
            aq.delete(idx);
          end
        end
        if (done[i]) begin
          idx = -1;
          for (int j = 0; j < dq.size(); j++) if (idx < 0 && dq[j].inst == i) idx = j;
          if (idx < 0) miss($sformatf("done%0d_unexpected", i));
          else begin
            chk32($sformatf("done_cycle%0d", i), cyc, dq[idx].cyc);
            chk32($sformatf("busy_at_done%0d", i), 32'(busy[i]), 32'd0);
            dq.delete(idx);
          end
        end
      end
    end
  end

  task automatic push_row(input int i, input int unsigned r, input int unsigned t);
    adr_t x;
    pkt_t y;
    int unsigned pk, e;
    pk = pkg_of(i);
    for (int unsigned p = 0; p < pk; p++) begin
      e = r * pk + p;
      x.inst = i; x.a = AW'(e); x.b = AW'(p); x.cyc = t + p * gap_of(i);
      aq.push_back(x);
      y.inst = i;
      y.a = pad(mem_a[i][e % 64], p, noe_of(i));
      y.b = pad(mem_b[i][p], p, noe_of(i));
      y.cyc = t + 2 + p * gap_of(i);
      pq.push_back(y);
    end
  endtask

  task automatic push_done(input int i, input int unsigned t);
    evt_t d;
    d.inst = i; d.cyc = t;
    dq.push_back(d);
  endtask

  task automatic wait_strobes(input int i, input int n);
    int c;
    c = 0;
    while (strobe_cnt[i] < n && c < 300) begin
      @(negedge clk); #1;
      c++;
    end
    if (strobe_cnt[i] < n) miss($sformatf("strobe%0d_timeout", i));
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk32({tag, "_a_rd_en"}, 32'(a_rd_en[i]), 32'd0);
    chk32({tag, "_b_rd_en"}, 32'(b_rd_en[i]), 32'd0);
    chk32({tag, "_a_addr"}, 32'(a_addr[i]), 32'd0);
    chk32({tag, "_b_addr"}, 32'(b_addr[i]), 32'd0);
    chkw({tag, "_first"}, fri[i], '0);
    chkw({tag, "_second"}, sri[i], '0);
    chk32({tag, "_strobe"}, 32'(orn[i]), 32'd0);
    chk32({tag, "_nom"}, nom[i], 32'd0);
    chk32({tag, "_busy"}, 32'(busy[i]), 32'd0);
    chk32({tag, "_done"}, 32'(done[i]), 32'd0);
  endtask

  // One job; spur pulses prepare during PRESENT/HOLD; abort resets in HOLD of that row.
  task automatic run_job(input int i, input int unsigned nrows, input bit spur, input int abort);
    int unsigned e_cyc, t, d, pk;
    int base;
    pk = pkg_of(i);
    rows[i] = 16'(nrows);
    @(negedge clk); start[i] = 1'b1;
    @(posedge clk); #1; e_cyc = cyc; start[i] = 1'b0;
    if (nrows == 0) begin
      push_done(i, e_cyc);
      @(negedge clk); #1;
      chk32("busy_rows0", 32'(busy[i]), 32'd0);
      repeat (3) @(negedge clk);
      return;
    end
    base = strobe_cnt[i];
    push_row(i, 0, e_cyc);
    @(negedge clk); #1;
    chk32("busy_after_start", 32'(busy[i]), 32'd1);
    chk32("nom_while_busy", nom[i], 32'(pk));
    for (int unsigned r = 0; r < nrows; r++) begin
      if (int'(r) == abort) begin
        wait_strobes(i, base + int'(r * pk) + 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero(i, "abort");
        pq.delete(); aq.delete(); dq.delete();
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (spur && pk > 1) begin
        wait_strobes(i, base + int'(r * pk) + 1);
        prep[i] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        prep[i] = 1'b0;
      end
      wait_strobes(i, base + int'((r + 1) * pk));
      d = $urandom_range(1, 4);
      repeat (d) @(negedge clk);
      #1; prep[i] = 1'b1;
      @(posedge clk); #1; t = cyc; prep[i] = 1'b0;
      if (r + 1 < nrows) push_row(i, r + 1, t);
      else begin
        push_done(i, t);
        @(negedge clk); #1;
        chk32("busy_end", 32'(busy[i]), 32'd0);
        chk32("nom_end", nom[i], 32'd0);
      end
    end
  endtask

  task automatic fill(input int i, input int first);
    for (int e = first; e < 64; e++)
      for (int k = 0; k < int'(NI); k++) begin
        mem_a[i][e][32*(NI-k)-1 -: 32] = $urandom;
        mem_b[i][e][32*(NI-k)-1 -: 32] = $urandom;
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tail;
    fill(0, 2);
    fill(1, 0);
    for (int k = 0; k < int'(NI); k++) begin
      mem_a[0][0][32*(NI-k)-1 -: 32] = 32'(k + 1);
      mem_b[0][0][32*(NI-k)-1 -: 32] = 32'h4000_0000;
    end
    mem_a[0][1] = '1;
    mem_b[0][1] = '1;

    #1 rst_n = 1'b0;
    #2;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed single row: tail package keeps lanes 0-1 only.
    run_job(0, 1, 1'b1, -1);
    tail = '0;
    tail[W-1 -: 64] = '1;
    chkw("tail_pad_a", last_a[0], tail);
    chkw("tail_pad_b", last_b[0], tail);

    run_job(0, 3, 1'b1, -1);
    run_job(0, 0, 1'b0, -1);
    fill(0, 0);
    for (int n = 0; n < 5; n++) run_job(0, $urandom_range(1, 4), 1'(n % 2), -1);

    run_job(0, 2, 1'b0, 1);
    run_job(0, 1, 1'b0, -1);

    run_job(1, 2, 1'b0, -1);
    run_job(1, 1, 1'b0, -1);
    run_job(1, 0, 1'b0, -1);

    repeat (5) @(negedge clk);
    chk32("pkt_queue_drained", 32'(pq.size()), 32'd0);
    chk32("addr_queue_drained", 32'(aq.size()), 32'd0);
    chk32("done_queue_drained", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
